// File: rtl/logit_argmax.sv
// logit_argmax: scans stored logits through the read port and latches
// the winning class, its logit and the top-1 minus top-2 margin.
module logit_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int LOGIT_W = 6,
  parameter int IDX_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [IDX_W-1:0]   read_addr,
  input  logic [LOGIT_W-1:0] read_data,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   class_idx,
  output logic [LOGIT_W-1:0] max_logit,
  output logic [LOGIT_W-1:0] margin
);
  typedef enum logic [1:0] {IDLE, SCAN, RESULT, DONE_ST} state_t;
  localparam logic signed [LOGIT_W-1:0] MIN = {1'b1, {(LOGIT_W-1){1'b0}}};
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);
  state_t state;
  logic [IDX_W-1:0] idx, best_idx;
  logic signed [LOGIT_W-1:0] best, second, d;
  assign d = $signed(read_data);
  assign read_addr = state == SCAN ? idx : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      best_idx <= '0;
      best <= MIN;
      second <= MIN;
      busy <= 1'b0;
      done <= 1'b0;
      class_idx <= '0;
      max_logit <= '0;
      margin <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            idx <= '0;
            busy <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (idx == '0) begin
            best <= d;
            best_idx <= '0;
            second <= MIN;
          end else if (d > best) begin
            second <= best;
            best <= d;
            best_idx <= idx;
          end else if (d > second) begin
            second <= d;
          end
          if (idx == LAST) state <= RESULT;
          else idx <= idx + 1'b1;
        end
        RESULT: begin
          class_idx <= best_idx;
          max_logit <= best;
          // true difference lies in 0..2^LOGIT_W-1, so the modular result is exact
          margin <= best - second;
          done <= 1'b1;
          busy <= 1'b0;
          state <= DONE_ST;
        end
        DONE_ST: if (!start) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
